// File: rtl/rca_seq_add32_pkg.sv
// Shared constants for the byte-serial adder: FSM encoding and default geometry.
package rca_seq_add32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_slice8.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module rca_slice8
  import rca_seq_add32_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
    assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = c[SLICE];
  assign cmsb_o = c[SLICE-1];

endmodule

// File: rtl/rca_seq_add32.sv
// Multi-cycle adder: one shared slice adder walks the operands LSB slice first,
// with the inter-slice carry held in a register. Start/ready/done handshake.
module rca_seq_add32
  import rca_seq_add32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [SLICE-1:0]  a_sl [NSLICE];
  logic [SLICE-1:0]  b_sl [NSLICE];
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout, slice_cmsb;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_split
    assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
    assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
  end

  rca_slice8 #(.SLICE(SLICE)) u_slice (
    .a_i    (a_sl[idx_q]),
    .b_i    (b_sl[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*SLICE +: SLICE] = slice_sum;
        end
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        // Top slice: its carry leaves through cout only, never back into slice 0.
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_rca_seq_add32.sv
// Directed bench for rca_seq_add32: vector table plus handshake, reset and hold sequences.
module tb_rca_seq_add32;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [31:0] a, b;
  logic        ready, busy, done, cout, ovf;
  logic [31:0] sum;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  rca_seq_add32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // One full add: accept, RUN for four edges, done pulse, back to ready.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " ready_run"}, 32'(ready), 32'd0);
    chk({tag, " sum_clr"}, sum, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk({tag, " early_done"}, 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " sum"}, sum, v.s);
    chk({tag, " cout"}, 32'(cout), 32'(v.co));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ov));
    $display("add %s a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d", tag, v.a, v.b, v.cin, sum, cout, ovf);
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 32'(done), 32'd0);
    chk({tag, " ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int ndone;
    logic [31:0] hs;
    logic        hc, ho;

    vecs[0] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sum", sum, 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset at E2 of an add; cout is still 1 from the last vector.
    @(negedge clk);
    a = 32'h00000012; b = 32'h00000034; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid sum_slice0", sum, 32'h00000046);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst sum", sum, 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    chk("midrst ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);
    $display("reset mid-run: ready=%0d sum=%h", ready, sum);
    run_vec(vecs[0], "after_rst");

    // Start held high; second operand pair waits until ready returns.
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h7FFFFFFF; b = 32'h00000001; cin = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("held first_cycle", 32'(c), 32'd4);
          chk("held first_sum", sum, 32'h2345678A);
          chk("held first_ovf", 32'(ovf), 32'd0);
        end else begin
          chk("held second_cycle", 32'(c), 32'd10);
          chk("held second_sum", sum, 32'h80000000);
          chk("held second_ovf", 32'(ovf), 32'd1);
          start = 1'b0;
        end
        $display("held-start done #%0d at cycle %0d sum=%h", ndone, c, sum);
      end
    end
    chk("held done_count", 32'(ndone), 32'd2);

    // Idle hold: results must not follow the toggling inputs.
    run_vec(vecs[3], "hold_src");
    hs = 32'h00000000; hc = 1'b1; ho = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; cin = c[0];
      @(posedge clk); #1;
      chk("hold sum", sum, hs);
      chk("hold cout", 32'(cout), 32'(hc));
      chk("hold ovf", 32'(ovf), 32'(ho));
      chk("hold done", 32'(done), 32'd0);
    end
    $display("hold: sum=%h cout=%0d ovf=%0d", sum, cout, ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
